// File: rtl/hdr_frame_ctrl.sv
// Frame scheduler for the HDR enhancement core: walks the frame in raster order and issues
// one 3x3-window request per pixel. Issue is gated by output-FIFO credit, and a valid/last
// delay line tags core results as they emerge.
module hdr_frame_ctrl #(
  parameter int PIPE_LAT   = 4,
  parameter int X_BITS     = 11,
  parameter int Y_BITS     = 11,
  parameter int FIFO_DEPTH = 8,
  parameter int CRED_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [X_BITS-1:0]    width_i,
  input  logic [Y_BITS-1:0]    height_i,
  output logic                 win_req_o,
  output logic [X_BITS-1:0]    win_x_o,
  output logic [Y_BITS-1:0]    win_y_o,
  input  logic                 win_ack_i,
  input  logic                 out_pop_i,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  output logic [CRED_BITS-1:0] credit_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CRED_BITS-1:0] CRED_FULL = CRED_BITS'(FIFO_DEPTH);

  state_t                state_r;
  state_t                state_next_s;
  logic [X_BITS-1:0]     x_r;
  logic [X_BITS-1:0]     w_r;
  logic [Y_BITS-1:0]     y_r;
  logic [Y_BITS-1:0]     h_r;
  logic [CRED_BITS-1:0]  credit_r;
  logic [PIPE_LAT-1:0]   vld_pipe_r;
  logic [PIPE_LAT-1:0]   last_pipe_r;
  logic                  done_r;

  logic                  dims_ok_s;
  logic                  start_ok_s;
  logic                  start_zero_s;
  logic                  req_s;
  logic                  busy_s;
  logic                  issue_s;
  logic                  x_end_s;
  logic                  y_end_s;
  logic                  pix_last_s;
  logic                  frame_end_s;

  // Handshake, raster-position and frame-end decodes
  always_comb begin
    dims_ok_s    = (width_i != {X_BITS{1'b0}}) && (height_i != {Y_BITS{1'b0}});
    start_ok_s   = (state_r == IDLE) && start_i && dims_ok_s;
    start_zero_s = (state_r == IDLE) && start_i && !dims_ok_s;
    issue_s      = req_s && win_ack_i;
    x_end_s      = (x_r == (w_r - X_BITS'(1)));
    y_end_s      = (y_r == (h_r - Y_BITS'(1)));
    pix_last_s   = x_end_s && y_end_s;
    frame_end_s  = vld_pipe_r[PIPE_LAT-1] && last_pipe_r[PIPE_LAT-1];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_next_s = RUN;
        else            state_next_s = IDLE;
      end
      RUN: begin
        if (issue_s && pix_last_s) state_next_s = DRAIN;
        else                       state_next_s = RUN;
      end
      DRAIN: begin
        if (frame_end_s) state_next_s = IDLE;
        else             state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State-decoded outputs; requests are withheld whenever the FIFO has no room
  always_comb begin
    req_s  = 1'b0;
    busy_s = 1'b0;
    case (state_r)
      IDLE: begin
        req_s  = 1'b0;
        busy_s = 1'b0;
      end
      RUN: begin
        req_s  = (credit_r != {CRED_BITS{1'b0}});
        busy_s = 1'b1;
      end
      DRAIN: begin
        req_s  = 1'b0;
        busy_s = 1'b1;
      end
      default: begin
        req_s  = 1'b0;
        busy_s = 1'b0;
      end
    endcase
  end

  // Frame dimensions and raster coordinates; coordinates hold until the fetch unit accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r <= {X_BITS{1'b0}};
      h_r <= {Y_BITS{1'b0}};
      x_r <= {X_BITS{1'b0}};
      y_r <= {Y_BITS{1'b0}};
    end else if (start_ok_s) begin
      w_r <= width_i;
      h_r <= height_i;
      x_r <= {X_BITS{1'b0}};
      y_r <= {Y_BITS{1'b0}};
    end else if (issue_s) begin
      if (x_end_s) begin
        x_r <= {X_BITS{1'b0}};
        y_r <= y_r + Y_BITS'(1);
      end else begin
        x_r <= x_r + X_BITS'(1);
      end
    end
  end

  // Credit: the core cannot stall, so every issue must own a FIFO slot before it enters
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= CRED_FULL;
    end else if (issue_s && out_pop_i) begin
      credit_r <= credit_r;
    end else if (issue_s) begin
      credit_r <= credit_r - CRED_BITS'(1);
    end else if (out_pop_i && (credit_r != CRED_FULL)) begin
      credit_r <= credit_r + CRED_BITS'(1);
    end
  end

  // Valid/last delay line matching the core's fixed latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_r  <= {PIPE_LAT{1'b0}};
      last_pipe_r <= {PIPE_LAT{1'b0}};
    end else begin
      vld_pipe_r[0]  <= issue_s;
      last_pipe_r[0] <= issue_s && pix_last_s;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        last_pipe_r[i] <= last_pipe_r[i-1];
      end
    end
  end

  // Done pulse: empty frame at start, or the tagged last pixel leaving the core
  always_ff @(posedge clk) begin
    if (rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= start_zero_s || ((state_r == DRAIN) && frame_end_s);
    end
  end

  assign win_req_o   = req_s;
  assign win_x_o     = x_r;
  assign win_y_o     = y_r;
  assign out_valid_o = vld_pipe_r[PIPE_LAT-1];
  assign out_last_o  = frame_end_s;
  assign credit_o    = credit_r;
  assign busy_o      = busy_s;
  assign done_o      = done_r;

endmodule

// File: tb/tb_hdr_frame_ctrl.sv
// Directed bench for hdr_frame_ctrl with default parameters (PIPE_LAT=4, FIFO_DEPTH=8).
module tb_hdr_frame_ctrl;

  localparam int XB = 11;
  localparam int YB = 11;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [XB-1:0] width_i;
  logic [YB-1:0] height_i;
  logic          win_req_o;
  logic [XB-1:0] win_x_o;
  logic [YB-1:0] win_y_o;
  logic          win_ack_i;
  logic          out_pop_i;
  logic          out_valid_o;
  logic          out_last_o;
  logic [CB-1:0] credit_o;
  logic          busy_o;
  logic          done_o;

  logic pop_man;
  logic pop_follow;
  int   n_asrt = 0;
  int   n_fail = 0;
  int   issues;
  int   nout;
  int   nlast;
  logic seen;

  hdr_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .width_i    (width_i),
    .height_i   (height_i),
    .win_req_o  (win_req_o),
    .win_x_o    (win_x_o),
    .win_y_o    (win_y_o),
    .win_ack_i  (win_ack_i),
    .out_pop_i  (out_pop_i),
    .out_valid_o(out_valid_o),
    .out_last_o (out_last_o),
    .credit_o   (credit_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Downstream FIFO model: either pops as soon as data arrives, or is driven by hand
  assign out_pop_i = pop_follow ? out_valid_o : pop_man;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int w, input int h);
    width_i  = XB'(w);
    height_i = YB'(h);
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; win_ack_i = 1'b0; pop_man = 1'b0; pop_follow = 1'b0;
    width_i = '0; height_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_req",    32'(win_req_o),   32'd0);
    chk("rst_x",      32'(win_x_o),     32'd0);
    chk("rst_y",      32'(win_y_o),     32'd0);
    chk("rst_valid",  32'(out_valid_o), 32'd0);
    chk("rst_last",   32'(out_last_o),  32'd0);
    chk("rst_busy",   32'(busy_o),      32'd0);
    chk("rst_done",   32'(done_o),      32'd0);
    chk("rst_credit", 32'(credit_o),    32'd8);

    // 3x2 frame at full rate; outputs 4 cycles after each issue
    win_ack_i = 1'b1; pop_follow = 1'b1;
    start_frame(3, 2);
    for (int j = 0; j < 12; j++) begin
      chk("t1_req", 32'(win_req_o), 32'(j < 6));
      if (j < 6) begin
        chk("t1_x", 32'(win_x_o), 32'(j % 3));
        chk("t1_y", 32'(win_y_o), 32'(j / 3));
      end
      chk("t1_valid", 32'(out_valid_o), 32'(j >= 4 && j <= 9));
      chk("t1_last",  32'(out_last_o),  32'(j == 9));
      chk("t1_busy",  32'(busy_o),      32'(j < 10));
      chk("t1_done",  32'(done_o),      32'(j == 10));
      tick();
    end
    chk("t1_credit", 32'(credit_o), 32'd8);

    // 4x4 frame with no pops: credit runs out after 8 issues
    pop_follow = 1'b0; pop_man = 1'b0;
    start_frame(4, 4);
    issues = 0;
    for (int j = 0; j < 14; j++) begin
      if (win_req_o && win_ack_i) issues++;
      tick();
    end
    chk("t2_issues", 32'(issues),   32'd8);
    chk("t2_req0",   32'(win_req_o), 32'd0);
    chk("t2_cred0",  32'(credit_o),  32'd0);
    chk("t2_busy",   32'(busy_o),    32'd1);
    pop_man = 1'b1;
    tick();
    pop_man = 1'b0;
    chk("t2_cred1", 32'(credit_o),  32'd1);
    chk("t2_req1",  32'(win_req_o), 32'd1);
    chk("t2_x8",    32'(win_x_o),   32'd0);
    chk("t2_y8",    32'(win_y_o),   32'd2);
    issues = 0;
    for (int j = 0; j < 6; j++) begin
      if (win_req_o && win_ack_i) issues++;
      tick();
    end
    chk("t2_one_more", 32'(issues),    32'd1);
    chk("t2_cred_end", 32'(credit_o),  32'd0);
    chk("t2_req_end",  32'(win_req_o), 32'd0);
    chk("t2_x9",       32'(win_x_o),   32'd1);
    chk("t2_y9",       32'(win_y_o),   32'd2);
    pop_man = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 60 && !seen; j++) begin
      tick();
      if (done_o) seen = 1'b1;
    end
    chk("t2_done_seen", 32'(seen), 32'd1);
    repeat (10) tick();
    pop_man = 1'b0;
    tick();
    chk("t2_cred_sat", 32'(credit_o), 32'd8);

    // 2x2 frame, fetch unit stalls 3 cycles on pixel (1,0)
    pop_follow = 1'b1;
    start_frame(2, 2);
    nout = 0;
    for (int j = 0; j < 13; j++) begin
      win_ack_i = !(j >= 1 && j <= 3);
      if (j >= 1 && j <= 4) begin
        chk("t3_req_hold", 32'(win_req_o), 32'd1);
        chk("t3_x_hold",   32'(win_x_o),   32'd1);
        chk("t3_y_hold",   32'(win_y_o),   32'd0);
      end
      chk("t3_valid", 32'(out_valid_o), 32'(j == 4 || j == 8 || j == 9 || j == 10));
      chk("t3_last",  32'(out_last_o),  32'(j == 10));
      chk("t3_done",  32'(done_o),      32'(j == 11));
      chk("t3_busy",  32'(busy_o),      32'(j < 11));
      if (out_valid_o) nout++;
      tick();
    end
    chk("t3_nout", 32'(nout), 32'd4);
    win_ack_i = 1'b1;

    // Zero-width frame: no requests, immediate done
    start_frame(0, 5);
    chk("t4_done", 32'(done_o),    32'd1);
    chk("t4_busy", 32'(busy_o),    32'd0);
    chk("t4_req",  32'(win_req_o), 32'd0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t4_req_idle",  32'(win_req_o), 32'd0);
      chk("t4_busy_idle", 32'(busy_o),    32'd0);
      chk("t4_done_once", 32'(done_o),    32'd0);
    end

    // Reset after 5 issues of an 8x8 frame
    pop_follow = 1'b0; pop_man = 1'b0;
    start_frame(8, 8);
    repeat (5) tick();
    chk("t5_cred_pre", 32'(credit_o), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy",   32'(busy_o),    32'd0);
    chk("t5_req",    32'(win_req_o), 32'd0);
    chk("t5_credit", 32'(credit_o),  32'd8);
    chk("t5_x",      32'(win_x_o),   32'd0);
    chk("t5_y",      32'(win_y_o),   32'd0);
    nout = 0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid_o) nout++;
      tick();
    end
    chk("t5_no_valid", 32'(nout), 32'd0);
    pop_follow = 1'b1;
    start_frame(2, 1);
    for (int j = 0; j < 8; j++) begin
      chk("t5b_req",   32'(win_req_o),   32'(j < 2));
      chk("t5b_valid", 32'(out_valid_o), 32'(j == 4 || j == 5));
      chk("t5b_last",  32'(out_last_o),  32'(j == 5));
      chk("t5b_done",  32'(done_o),      32'(j == 6));
      tick();
    end

    // Issue+pop with credit 3, and a start pulse during RUN that must be ignored
    pop_follow = 1'b0; pop_man = 1'b0;
    start_frame(3, 3);
    nout = 0; nlast = 0; seen = 1'b0;
    for (int j = 0; j < 40 && !seen; j++) begin
      pop_man = (j >= 5);
      start_i = (j == 6);
      if (j == 6) begin
        width_i  = XB'(1);
        height_i = YB'(1);
      end
      if (j == 5 || j == 6) chk("t6_credit", 32'(credit_o), 32'd3);
      if (j == 6) begin
        chk("t6_x6", 32'(win_x_o), 32'd0);
        chk("t6_y6", 32'(win_y_o), 32'd2);
      end
      if (j == 7) begin
        chk("t6_x7", 32'(win_x_o), 32'd1);
        chk("t6_y7", 32'(win_y_o), 32'd2);
      end
      if (out_valid_o) nout++;
      if (out_valid_o && out_last_o) nlast++;
      if (done_o) seen = 1'b1;
      tick();
    end
    start_i = 1'b0; pop_man = 1'b0;
    chk("t6_done_seen", 32'(seen),   32'd1);
    chk("t6_nout",      32'(nout),   32'd9);
    chk("t6_nlast",     32'(nlast),  32'd1);
    chk("t6_busy",      32'(busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
